// File: rtl/phrase_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phrase_writer_pkg
//  Description : Shared definitions for the character-map write path and the
//                text renderer: screen geometry, command encodings, FSM
//                state encoding and the cell-address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package phrase_writer_pkg;

    // Screen geometry in 8x8 character cells (800x600 pixels)
    localparam int COLS   = 100;
    localparam int ROWS   = 75;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 13;

    localparam logic [7:0] FILL_CHAR    = 8'h20;
    localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

    // Sized versions of the geometry limits for direct comparison
    localparam logic [6:0]        COL_LAST      = 7'(COLS - 1);
    localparam logic [6:0]        ROW_LAST      = 7'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST     = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ROW_STEP = ADDR_W'(COLS);

    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_SET_CURSOR = 2'b01,
        OP_WRITE      = 2'b10,
        OP_CLEAR      = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_CLEAR  = 2'd2
    } state_e;

    // Linear cell address col + row*COLS. The multiply by 100 is written as
    // shift-adds (64 + 32 + 4), so it is tied to COLS == 100.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col,
                                                    input logic [6:0] row);
        logic [ADDR_W-1:0] w_row;
        logic [ADDR_W-1:0] w_col;
        w_row = {{(ADDR_W-7){1'b0}}, row};
        w_col = {{(ADDR_W-7){1'b0}}, col};
        return (w_row << 6) + (w_row << 5) + (w_row << 2) + w_col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phrase_writer_text_cursor.sv
`default_nettype none
// ============================================================================
//  Module      : phrase_writer_text_cursor
//  Description : Text cursor holding column, row and linear cell address.
//                Supports zero, clamped load, increment (with row and screen
//                wrap) and newline. The linear address is computed once on
//                load and only stepped afterwards.
//  Ports       : clk        - system clock
//                reset      - synchronous active-low reset
//                i_zero     - move cursor to cell 0
//                i_load     - load cursor from i_load_col / i_load_row
//                i_load_col - requested column (clamped to COLS-1)
//                i_load_row - requested row (clamped to ROWS-1)
//                i_incr     - advance one cell
//                i_newline  - move to column 0 of the next row
//                o_addr     - current linear cell address
//  Revision    : 1.0 - initial release
// ============================================================================
module phrase_writer_text_cursor
    import phrase_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_zero,
    input  logic              i_load,
    input  logic [6:0]        i_load_col,
    input  logic [6:0]        i_load_row,
    input  logic              i_incr,
    input  logic              i_newline,
    output logic [ADDR_W-1:0] o_addr
);

    logic [6:0]        r_col;
    logic [6:0]        r_row;
    logic [ADDR_W-1:0] r_addr;

    logic [6:0] w_ld_col;
    logic [6:0] w_ld_row;

    assign w_ld_col = (i_load_col > COL_LAST) ? COL_LAST : i_load_col;
    assign w_ld_row = (i_load_row > ROW_LAST) ? ROW_LAST : i_load_row;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_zero) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_col  <= w_ld_col;
            r_row  <= w_ld_row;
            r_addr <= cell_addr(w_ld_col, w_ld_row);
        end else if (i_incr) begin
            if (r_addr == ADDR_LAST) begin
                r_col  <= '0;
                r_row  <= '0;
                r_addr <= '0;
            end else if (r_col == COL_LAST) begin
                r_col  <= '0;
                r_row  <= r_row + 7'd1;
                r_addr <= r_addr + 1'b1;
            end else begin
                r_col  <= r_col + 7'd1;
                r_addr <= r_addr + 1'b1;
            end
        end else if (i_newline) begin
            r_col <= '0;
            if (r_row == ROW_LAST) begin
                r_row  <= '0;
                r_addr <= '0;
            end else begin
                // Skip the rest of this row: addr - col + COLS
                r_row  <= r_row + 7'd1;
                r_addr <= r_addr + ADDR_ROW_STEP - {{(ADDR_W-7){1'b0}}, r_col};
            end
        end
    end

    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/phrase_writer.sv
`default_nettype none
// ============================================================================
//  Module      : phrase_writer
//  Description : Write side of the text-mode character map. Accepts cursor
//                and clear commands plus a stream of ASCII characters and
//                drives the single write port of the COLSxROWS character RAM.
//                Build option: define PHRASE_NEWLINE_EN to treat 8'h0A as a
//                newline (no write, cursor to start of next row).
//  Ports       : clk        - system clock
//                reset      - synchronous active-low reset
//                cmd_valid  / cmd_ready  / cmd_op / cmd_col / cmd_row
//                           - command channel (accepted in IDLE only)
//                char_valid / char_ready / char_data / char_last
//                           - character channel (accepted in STREAM only)
//                wr_en / wr_address / wr_data
//                           - RAM write port, one cycle after acceptance
//                busy       - high whenever not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module phrase_writer
    import phrase_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [6:0]        cmd_col,
    input  logic [6:0]        cmd_row,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [7:0]        char_data,
    input  logic              char_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [7:0]        wr_data,
    output logic              busy
);

    state_e r_state;
    state_e w_state_next;

    logic              w_cur_zero;
    logic              w_cur_load;
    logic              w_cur_incr;
    logic              w_cur_newline;
    logic [ADDR_W-1:0] w_cur_addr;

    logic              w_wr_fire;
    logic [7:0]        w_wr_byte;

    phrase_writer_text_cursor u_cursor (
        .clk        (clk),
        .reset      (reset),
        .i_zero     (w_cur_zero),
        .i_load     (w_cur_load),
        .i_load_col (cmd_col),
        .i_load_row (cmd_row),
        .i_incr     (w_cur_incr),
        .i_newline  (w_cur_newline),
        .o_addr     (w_cur_addr)
    );

    assign cmd_ready  = (r_state == ST_IDLE);
    assign char_ready = (r_state == ST_STREAM);
    assign busy       = (r_state != ST_IDLE);

    always_comb begin
        w_state_next  = r_state;
        w_cur_zero    = 1'b0;
        w_cur_load    = 1'b0;
        w_cur_incr    = 1'b0;
        w_cur_newline = 1'b0;
        w_wr_fire     = 1'b0;
        w_wr_byte     = char_data;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_SET_CURSOR: w_cur_load = 1'b1;
                        OP_WRITE: begin
                            w_cur_load   = 1'b1;
                            w_state_next = ST_STREAM;
                        end
                        OP_CLEAR: begin
                            w_cur_zero   = 1'b1;
                            w_state_next = ST_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end

            ST_STREAM: begin
                if (char_valid) begin
`ifdef PHRASE_NEWLINE_EN
                    if (char_data == NEWLINE_CHAR) begin
                        w_cur_newline = 1'b1;
                    end else begin
                        w_wr_fire  = 1'b1;
                        w_cur_incr = 1'b1;
                    end
`else
                    w_wr_fire  = 1'b1;
                    w_cur_incr = 1'b1;
`endif
                    if (char_last) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_CLEAR: begin
                w_wr_fire  = 1'b1;
                w_wr_byte  = FILL_CHAR;
                w_cur_incr = 1'b1;
                // The increment at the last cell wraps the cursor back to 0
                if (w_cur_addr == ADDR_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
        end else begin
            r_state <= w_state_next;
            wr_en   <= w_wr_fire;
            // Address and data hold their last value between writes
            if (w_wr_fire) begin
                wr_address <= w_cur_addr;
                wr_data    <= w_wr_byte;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phrase_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phrase_writer
//  Description : Self-checking bench for phrase_writer. A screen-level model
//                tracks the cursor as a single linear cell number and
//                predicts handshakes and RAM writes every cycle; directed
//                phrases pin the model with literal addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phrase_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [6:0]  cmd_col = '0;
    logic [6:0]  cmd_row = '0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [7:0]  char_data = '0;
    logic        char_last = 1'b0;
    logic        wr_en;
    logic [12:0] wr_address;
    logic [7:0]  wr_data;
    logic        busy;

    phrase_writer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_col    (cmd_col),
        .cmd_row    (cmd_row),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_data  (char_data),
        .char_last  (char_last),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Screen-level model: mode 0 idle, 1 streaming, 2 clearing
    int          m_mode = 0;
    int          m_pos  = 0;
    logic        m_we   = 1'b0;
    logic [12:0] m_a    = '0;
    logic [7:0]  m_d    = '0;
    bit          m_on   = 1'b0;

    logic [20:0] wlog[$];
    logic [7:0]  phr[$];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int clampi(input int v, input int lim);
        return (v >= lim) ? lim - 1 : v;
    endfunction

    always @(posedge clk) begin
        m_on = 1'b1;
        if (!reset) begin
            m_mode = 0; m_pos = 0; m_we = 1'b0; m_a = '0; m_d = '0;
        end else begin
            m_we = 1'b0;
            if (m_mode == 0) begin
                if (cmd_valid) begin
                    if (cmd_op == 2'b01 || cmd_op == 2'b10)
                        m_pos = clampi(int'(cmd_col), 100) + 100 * clampi(int'(cmd_row), 75);
                    if (cmd_op == 2'b10) m_mode = 1;
                    if (cmd_op == 2'b11) begin m_pos = 0; m_mode = 2; end
                end
            end else if (m_mode == 1) begin
                if (char_valid) begin
`ifdef PHRASE_NEWLINE_EN
                    if (char_data == 8'h0A) begin
                        m_pos = ((m_pos / 100 + 1) % 75) * 100;
                    end else begin
                        m_we = 1'b1; m_a = 13'(m_pos); m_d = char_data;
                        m_pos = (m_pos + 1) % 7500;
                    end
`else
                    m_we = 1'b1; m_a = 13'(m_pos); m_d = char_data;
                    m_pos = (m_pos + 1) % 7500;
`endif
                    if (char_last) m_mode = 0;
                end
            end else begin
                m_we = 1'b1; m_a = 13'(m_pos); m_d = 8'h20;
                m_pos = (m_pos + 1) % 7500;
                if (m_pos == 0) m_mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("wr_en", 32'(wr_en), 32'(m_we));
            chk("wr_address", 32'(wr_address), 32'(m_a));
            chk("wr_data", 32'(wr_data), 32'(m_d));
            chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0));
            chk("char_ready", 32'(char_ready), 32'(m_mode == 1));
            chk("busy", 32'(busy), 32'(m_mode != 0));
            if (wr_en === 1'b1) wlog.push_back({wr_address, wr_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [6:0] col,
                            input logic [6:0] row);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_col = col; cmd_row = row;
        for (int i = 0; i < 20000; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            tick();
        end
        chk("cmd_accept_in_time", 32'(ok), 32'd1);
        tick();
        cmd_valid = 1'b0; cmd_op = 2'b00;
    endtask

    task automatic send_phrase(input bit gaps);
        for (int k = 0; k < phr.size(); k++) begin
            bit ok = 1'b0;
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                char_valid = 1'b0; char_data = 8'($urandom); char_last = 1'($urandom);
                tick();
            end
            char_valid = 1'b1; char_data = phr[k]; char_last = (k == phr.size() - 1);
            for (int i = 0; i < 200; i++) begin
                if (char_ready) begin ok = 1'b1; break; end
                tick();
            end
            chk("char_accept_in_time", 32'(ok), 32'd1);
            tick();
        end
        char_valid = 1'b0; char_last = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            tick();
        end
        chk("return_to_idle", 32'(ok), 32'd1);
    endtask

    initial begin
        int base;

        // Reset state
        reset = 1'b0;
        tick(); tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_char_ready", 32'(char_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        // SET_CURSOR then WRITE "HI" at col 5 row 2, back-to-back characters
        send_cmd(2'b01, 7'd5, 7'd2);
        send_cmd(2'b10, 7'd5, 7'd2);
        base = wlog.size();
        phr = '{8'h48, 8'h49};
        send_phrase(1'b0);
        chk("hi_last_wr_en", 32'(wr_en), 32'd1);
        chk("hi_last_addr", 32'(wr_address), 32'd206);
        chk("hi_idle_after", 32'(cmd_ready), 32'd1);
        chk("hi_busy_after", 32'(busy), 32'd0);
        tick();
        chk("hi_count", 32'(wlog.size() - base), 32'd2);
        chk("hi_w0", 32'(wlog[base]), 32'({13'd205, 8'h48}));
        chk("hi_w1", 32'(wlog[base+1]), 32'({13'd206, 8'h49}));

        // Row wrap
        send_cmd(2'b10, 7'd99, 7'd0);
        base = wlog.size();
        phr = '{8'h41, 8'h42};
        send_phrase(1'b1);
        tick();
        chk("rowwrap_w0", 32'(wlog[base]), 32'({13'd99, 8'h41}));
        chk("rowwrap_w1", 32'(wlog[base+1]), 32'({13'd100, 8'h42}));

        // Full-screen wrap
        send_cmd(2'b10, 7'd99, 7'd74);
        base = wlog.size();
        phr = '{8'h58, 8'h59};
        send_phrase(1'b0);
        tick();
        chk("scrwrap_w0", 32'(wlog[base]), 32'({13'd7499, 8'h58}));
        chk("scrwrap_w1", 32'(wlog[base+1]), 32'({13'd0, 8'h59}));

        // Clamped coordinates
        send_cmd(2'b10, 7'd120, 7'd90);
        base = wlog.size();
        phr = '{8'h51};
        send_phrase(1'b0);
        tick();
        chk("clamp_w0", 32'(wlog[base]), 32'({13'd7499, 8'h51}));

        // Newline handling
        send_cmd(2'b10, 7'd10, 7'd3);
        base = wlog.size();
        phr = '{8'h41, 8'h0A, 8'h42};
        send_phrase(1'b0);
        tick();
        chk("nl_w0", 32'(wlog[base]), 32'({13'd310, 8'h41}));
`ifdef PHRASE_NEWLINE_EN
        chk("nl_count", 32'(wlog.size() - base), 32'd2);
        chk("nl_w1", 32'(wlog[base+1]), 32'({13'd400, 8'h42}));
`else
        chk("nl_count", 32'(wlog.size() - base), 32'd3);
        chk("nl_w1", 32'(wlog[base+1]), 32'({13'd311, 8'h0A}));
        chk("nl_w2", 32'(wlog[base+2]), 32'({13'd312, 8'h42}));
`endif

        // Full CLEAR with a character held on the input throughout
        char_valid = 1'b1; char_data = 8'h55; char_last = 1'b0;
        base = wlog.size();
        send_cmd(2'b11, 7'd0, 7'd0);
        wait_idle(8000);
        tick(); tick();
        char_valid = 1'b0;
        chk("clear_count", 32'(wlog.size() - base), 32'd7500);
        chk("clear_first", 32'(wlog[base]), 32'({13'd0, 8'h20}));
        chk("clear_last", 32'(wlog[base+7499]), 32'({13'd7499, 8'h20}));

        // Reset in the middle of a CLEAR
        send_cmd(2'b11, 7'd0, 7'd0);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                if (wr_en && wr_address == 13'd3000) begin ok = 1'b1; break; end
                tick();
            end
            chk("clear_reaches_3000", 32'(ok), 32'd1);
        end
        reset = 1'b0;
        tick();
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        send_cmd(2'b10, 7'd0, 7'd0);
        base = wlog.size();
        phr = '{8'h5A};
        send_phrase(1'b0);
        tick();
        chk("midrst_z", 32'(wlog[base]), 32'({13'd0, 8'h5A}));

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            int r = $urandom_range(0, 9);
            if (r < 2) begin
                char_valid = 1'($urandom); char_data = 8'($urandom); char_last = 1'($urandom);
                send_cmd((r == 0) ? 2'b00 : 2'b01, 7'($urandom_range(0, 127)),
                         7'($urandom_range(0, 127)));
                char_valid = 1'b0; char_last = 1'b0;
            end else begin
                int len = $urandom_range(1, 6);
                send_cmd(2'b10, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
                phr.delete();
                for (int k = 0; k < len; k++)
                    phr.push_back(($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom));
                send_phrase(1'($urandom));
            end
        end

        wait_idle(100);
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phrase_writer.md
Name: phrase_writer

Overview:
- Write-side counterpart of the text-mode character renderer.
- Accepts cursor/clear commands and a byte stream of ASCII characters, and produces the single-port write strobe, address and data for the 100x75 character-map RAM.
- The renderer reads that RAM to draw 8x8 glyphs.
- Sits between the game/CPU-side logic and the character-map RAM write port.

Parameters:
COLS, 100, characters per text row (800 px / 8)
ROWS, 75, text rows (600 px / 8)
ADDR_W, 13, character-map RAM address width (COLS*ROWS-1 = 7499 must fit)
FILL_CHAR, 8'h20, byte written to every cell by CLEAR

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  2  00 NOP, 01 SET_CURSOR, 10 WRITE, 11 CLEAR
cmd_col  input  7  target column for SET_CURSOR/WRITE
cmd_row  input  7  target row for SET_CURSOR/WRITE
char_valid  input  1  character offered
char_ready  output  1  character accepted when char_valid && char_ready
char_data  input  8  ASCII code
char_last  input  1  marks final character of a WRITE phrase
wr_en  output  1  RAM write strobe (drives the renderer's "ready")
wr_address  output  ADDR_W  RAM write address = col + COLS*row
wr_data  output  8  byte to write
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: a clock edge with reset==0 sets the state to IDLE and clears the cursor (col=0, row=0, linear address 0). It also sets wr_en=0, wr_address=0, wr_data=0, cmd_ready=1, char_ready=0, busy=0. This applies mid-stream or mid-clear: any partially written phrase or clear is abandoned.
- States: IDLE, STREAM, CLEAR.
- cmd_ready = (state==IDLE); char_ready = (state==STREAM). Both are combinational from state. cmd_ready is never high in the same cycle as char_ready.
- IDLE handling of an accepted command:
  - NOP: no effect.
  - SET_CURSOR: load the cursor, stay in IDLE.
  - WRITE: load the cursor, go to STREAM.
  - CLEAR: zero the cursor, go to CLEAR.
- Coordinate clamping: col>=COLS clamps to COLS-1; row>=ROWS clamps to ROWS-1.
- Address arithmetic: the linear address is computed once at cursor load (col + row*COLS, using a shift-add form permitted). After that it is incremented only; no per-character multiply.
- STREAM: each accepted character produces, on the next clock edge, wr_en=1, wr_address=current linear address, wr_data=char_data. Latency is exactly 1 cycle, and a sustained rate of 1 character/cycle must be supported.
- Cursor advance: col+1. At col==COLS-1, col wraps to 0 and row increments. At the last cell (addr COLS*ROWS-1), col, row and address all wrap to 0.
- char_last accepted: perform that write, then return to IDLE (cmd_ready high in the following cycle). The cursor stays after the last character.
- CLEAR: one write per cycle of FILL_CHAR to addresses 0..COLS*ROWS-1 in order, taking 7500 cycles. After the write of the final address, return to IDLE with the cursor at 0. Characters are not accepted during CLEAR.
- wr_en is 0 in every cycle not carrying a write. wr_address and wr_data hold their last values when wr_en is 0.
- char_valid in IDLE is ignored (not consumed). cmd_valid outside IDLE is ignored (not consumed).

Optional Feature:
Macro PHRASE_NEWLINE_EN.
- Defined: an accepted char_data==8'h0A in STREAM writes nothing (wr_en stays 0). The cursor moves to col 0 of the next row, with row wrap ROWS-1 -> 0. If char_last accompanies it, return to IDLE.
- Undefined: 8'h0A is written and advances the cursor like any other byte.

Decomposition:
- Shared package: cmd_op encodings, state enum, constants COLS, ROWS, CELLS=COLS*ROWS, FILL_CHAR. The renderer uses the same package for its address calculation.
- One natural sub-module, text_cursor: holds col/row/linear address, with load (clamped), increment and newline operations and wrap logic. The FSM and handshakes stay in phrase_writer.

Test Plan:
- Reset, then SET_CURSOR (col 5,row 2), then WRITE (col 5,row 2) with "HI" (last on 'I') -> writes 0x48@205, 0x49@206 on consecutive cycles, 1 cycle after each accept; busy drops after 'I'; cmd_ready=1 next cycle.
- WRITE (col 99,row 0), chars 'A','B' -> 'A'@99, 'B'@100 (row wrap). WRITE (col 99,row 74), 'X','Y' -> 'X'@7499, 'Y'@0 (full wrap).
- CLEAR -> exactly 7500 wr_en pulses of 0x20, addresses 0..7499 ascending; cmd_ready low throughout; char_valid held high is never consumed.
- WRITE with col 120,row 90 -> clamped; first char written @7499.
- Assert reset low mid-CLEAR at address 3000 -> next cycle wr_en=0, state IDLE, cursor 0; a subsequent WRITE (col 0,row 0) 'Z' -> 0x5A@0.
- With PHRASE_NEWLINE_EN: WRITE (col 10,row 3) "A\nB" -> 'A'@310, no write for 0x0A, 'B'@400. Without the macro: 0x0A@311, 'B'@312.
